// File: rtl/updown_dir_ctrl_if.sv
// Signal bundle between the direction sequencer (slave) and the counter/button side (master).
// There is no valid/ready handshake: every signal is a level, sampled or produced each clock.
interface updown_dir_ctrl_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] count;
    logic             mode;
    logic             btn_raw;
    logic [WIDTH-1:0] lo_lim;
    logic [WIDTH-1:0] hi_lim;
    logic             ctrl;
    logic             rev;
    logic [7:0]       rev_cnt;
    logic             lim_err;
    logic             dir_dbg;

    modport master (
        output count, mode, btn_raw, lo_lim, hi_lim,
        input  ctrl, rev, rev_cnt, lim_err, dir_dbg
    );

    modport slave (
        input  count, mode, btn_raw, lo_lim, hi_lim,
        output ctrl, rev, rev_cnt, lim_err, dir_dbg
    );
endinterface

// File: rtl/updown_dir_ctrl.sv
// Up/down direction sequencer: auto bounce between limits or manual toggle by button.
// Define UPDOWN_DIR_DEBOUNCE_EN to add the DEB_CYCLES debounce counter on the button path.
module updown_dir_ctrl #(
    parameter int WIDTH      = 3,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    updown_dir_ctrl_if.slave   bus
);
    localparam logic [0:0] DIR_DOWN = 1'b0;
    localparam logic [0:0] DIR_UP   = 1'b1;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    logic [0:0] dir_q;
    logic [0:0] dir_d;
    logic       sync1_q;
    logic       btn_s_q;
    logic       btn_db_q;
    logic       btn_db_d;
    logic       press;
    logic       rev_q;
    logic       rev_d;
    logic [7:0] rev_cnt_q;
    logic [7:0] rev_cnt_d;
    logic       lim_err;
    logic       at_hi;
    logic       at_lo;
    logic       auto_rev;
    logic       man_flip;
    logic       flip;

    assign lim_err = (bus.lo_lim >= bus.hi_lim);
    assign at_hi   = (bus.count >= bus.hi_lim);
    assign at_lo   = (bus.count <= bus.lo_lim);

    // Inclusive compares pull an out-of-range count back toward the window.
    always_comb begin
        auto_rev = 1'b0;
        if (bus.mode && !lim_err) begin
            case (dir_q)
                DIR_UP:  auto_rev = at_hi;
                default: auto_rev = at_lo;
            endcase
        end
    end

    assign man_flip = press & ~bus.mode;
    assign flip     = auto_rev | man_flip;
    assign dir_d    = flip ? ~dir_q : dir_q;
    assign rev_d    = (dir_d != dir_q);

    always_comb begin
        rev_cnt_d = rev_cnt_q;
        if (rev_q && (rev_cnt_q != 8'hFF)) begin
            rev_cnt_d = rev_cnt_q + 8'd1;
        end
    end

`ifdef UPDOWN_DIR_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             deb_done;

    // The debounced level moves only after DEB_CYCLES consecutive mismatching cycles.
    assign deb_done = (btn_s_q != btn_db_q) && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));

    always_comb begin
        deb_cnt_d = '0;
        btn_db_d  = btn_db_q;
        if (btn_s_q != btn_db_q) begin
            if (deb_done) begin
                btn_db_d = btn_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign press = deb_done & btn_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
        end
    end
`else
    assign btn_db_d = btn_s_q;
    assign press    = btn_s_q & ~btn_db_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            sync1_q  <= bus.btn_raw;
            btn_s_q  <= sync1_q;
            btn_db_q <= btn_db_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q     <= DIR_DOWN;
            rev_q     <= 1'b0;
            rev_cnt_q <= 8'd0;
        end else begin
            dir_q     <= dir_d;
            rev_q     <= rev_d;
            rev_cnt_q <= rev_cnt_d;
        end
    end

    // ctrl is Mealy so the counter turns on the very edge a limit is reached.
    assign bus.ctrl    = dir_d[0];
    assign bus.rev     = rev_q;
    assign bus.rev_cnt = rev_cnt_q;
    assign bus.lim_err = lim_err;
    assign bus.dir_dbg = dir_q[0];
endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl with an expected-value queue and a free-running monitor.
// Press latency and glitch behaviour adapt to UPDOWN_DIR_DEBOUNCE_EN.
module tb_updown_dir_ctrl;
    localparam int WIDTH      = 3;
    localparam int DEB_CYCLES = 4;
    localparam int VW         = 15;
    localparam int W          = 2 * VW;
`ifdef UPDOWN_DIR_DEBOUNCE_EN
    localparam int PRESS_LAT    = 2 + DEB_CYCLES;
    localparam bit GLITCH_FLIPS = 1'b0;
`else
    localparam int PRESS_LAT    = 3;
    localparam bit GLITCH_FLIPS = 1'b1;
`endif

    // Vector layout: {count[2:0], ctrl, rev, lim_err, dir, rev_cnt[7:0]}
    localparam logic [VW-1:0] M_CNT  = 15'h7000;
    localparam logic [VW-1:0] M_CTRL = 15'h0800;
    localparam logic [VW-1:0] M_REV  = 15'h0400;
    localparam logic [VW-1:0] M_LIM  = 15'h0200;
    localparam logic [VW-1:0] M_DIR  = 15'h0100;
    localparam logic [VW-1:0] M_RC   = 15'h00FF;
    localparam logic [VW-1:0] M_ALL  = 15'h7FFF;

    logic clk = 1'b0;
    logic rst;
    logic follow;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    event         chk_now;

    int b_cnt [8] = '{2, 3, 4, 5, 4, 3, 2, 3};
    int b_ctrl[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int b_rev [8] = '{0, 1, 0, 0, 1, 0, 0, 1};
    int b_dir [8] = '{0, 1, 1, 1, 0, 0, 0, 1};
    int b_rc  [8] = '{0, 0, 1, 1, 1, 2, 2, 2};

    updown_dir_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    updown_dir_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    function automatic logic [VW-1:0] mk(input int cnt, input bit c, input bit r,
                                         input bit l, input bit d, input int rc);
        return {3'(cnt), c, r, l, d, 8'(rc)};
    endfunction

    task automatic expect_v(input string name, input logic [VW-1:0] mask, input logic [VW-1:0] val);
        exp_q.push_back({mask, val});
        name_q.push_back(name);
    endtask

    // One clock: ctrl seen just before the edge drives the behavioural counter.
    task automatic tick();
        logic c;
        @(negedge clk);
        c = ifc.ctrl;
        @(posedge clk);
        #1;
        if (follow) ifc.count = c ? ifc.count + 3'd1 : ifc.count - 3'd1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0]  e;
        logic [VW-1:0] act;
        logic [VW-1:0] m;
        logic [VW-1:0] v;
        string         n;
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                m   = e[W-1:VW];
                v   = e[VW-1:0];
                act = {ifc.count, ifc.ctrl, ifc.rev, ifc.lim_err, ifc.dir_dbg, ifc.rev_cnt};
                checks++;
                if ((act & m) != (v & m)) begin
                    errors++;
                    $display("FAIL %s @%0t: actual count=%0d ctrl=%b rev=%b lim_err=%b dir=%b rev_cnt=%0d; required count=%0d ctrl=%b rev=%b lim_err=%b dir=%b rev_cnt=%0d (mask %h)",
                             n, $time, act[14:12], act[11], act[10], act[9], act[8], act[7:0],
                             v[14:12], v[11], v[10], v[9], v[8], v[7:0], m);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int L;
        int rc;
        L = PRESS_LAT;
        rst = 1'b0;
        follow = 1'b0;
        ifc.count = 3'd0;
        ifc.mode = 1'b0;
        ifc.btn_raw = 1'b0;
        ifc.lo_lim = 3'd2;
        ifc.hi_lim = 3'd5;
        #1;

        // Reset held: idle outputs, then ctrl still follows the next-direction logic.
        expect_v("reset_idle", M_ALL, mk(0, 0, 0, 0, 0, 0));
        tick();
        ifc.mode = 1'b1;
        ifc.lo_lim = 3'd0;
        expect_v("reset_ctrl_mealy", M_ALL, mk(0, 1, 0, 0, 0, 0));
        tick();

        // Auto bounce 2..5 with the behavioural counter closing the loop.
        rst = 1'b1;
        ifc.count = 3'd2;
        ifc.lo_lim = 3'd2;
        ifc.hi_lim = 3'd5;
        follow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_v($sformatf("bounce_%0d", i), M_ALL,
                     mk(b_cnt[i], b_ctrl[i][0], b_rev[i][0], 0, b_dir[i][0], b_rc[i]));
            tick();
        end

        // Invalid limits while UP: no reversals, counter wraps 7->0.
        ifc.lo_lim = 3'd5;
        ifc.hi_lim = 3'd3;
        ifc.count = 3'd6;
        for (int k = 0; k < 20; k++) begin
            expect_v($sformatf("lim_err_%0d", k), M_ALL, mk((6 + k) % 8, 1, 0, 1, 1, 3));
            tick();
        end

        // Manual mode: button held 10 cycles gives exactly one flip.
        follow = 1'b0;
        ifc.mode = 1'b0;
        ifc.lo_lim = 3'd2;
        ifc.hi_lim = 3'd5;
        ifc.count = 3'd4;
        for (int k = 1; k <= 20; k++) begin
            ifc.btn_raw = (k <= 10);
            expect_v($sformatf("press_E%0d", k), M_ALL,
                     mk(4, k < L, k == L + 1, 0, k <= L, (k > L + 1) ? 4 : 3));
            tick();
        end

        // Three-cycle glitch.
        for (int k = 1; k <= 15; k++) begin
            ifc.btn_raw = (k <= 3);
            expect_v($sformatf("glitch_E%0d", k), M_ALL,
                     mk(4, GLITCH_FLIPS && k >= 3, GLITCH_FLIPS && k == 4, 0,
                        GLITCH_FLIPS && k >= 4, (GLITCH_FLIPS && k >= 5) ? 5 : 4));
            tick();
        end

        // Steer into UP in auto mode (count at lo), then let rev settle.
        ifc.mode = 1'b1;
        ifc.count = 3'd2;
        expect_v("auto_to_up", M_CNT | M_CTRL | M_LIM, mk(2, 1, 0, 0, 0, 0));
        tick();
        ifc.count = 3'd3;
        expect_v("settle_up", M_CTRL | M_DIR, mk(3, 1, 0, 0, 1, 0));
        tick();
        expect_v("settle_cnt", M_ALL, mk(3, 1, 0, 0, 1, 5));
        tick();

        // Debounced press lands on the same cycle as count == hi_lim: single reversal.
        for (int k = 1; k <= L + 6; k++) begin
            ifc.btn_raw = (k <= L + 2);
            ifc.count = (k == L) ? 3'd5 : 3'd3;
            expect_v($sformatf("simul_%0d", k), M_ALL,
                     mk((k == L) ? 5 : 3, k < L, k == L + 1, 0, k <= L, (k > L + 1) ? 6 : 5));
            tick();
        end

        // Saturation: 2..3 window reverses every cycle.
        ifc.btn_raw = 1'b0;
        ifc.lo_lim = 3'd2;
        ifc.hi_lim = 3'd3;
        ifc.count = 3'd2;
        follow = 1'b1;
        for (int n = 0; n <= 300; n++) begin
            if (n == 0 || n == 100 || n == 249 || n == 250 || n == 251 || n == 300) begin
                rc = (n == 0) ? 6 : ((5 + n > 255) ? 255 : 5 + n);
                expect_v($sformatf("sat_n%0d", n), M_REV | M_RC, mk(0, 0, n != 0, 0, 0, rc));
            end
            tick();
        end

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        rst = 1'b0;
        #1;
        expect_v("async_reset", M_REV | M_DIR | M_RC | M_LIM, mk(0, 0, 0, 0, 0, 0));
        -> chk_now;
        follow = 1'b0;
        tick();
        rst = 1'b1;

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
